// File: rtl/time_alarm_setter.sv
// Push-button front end for the 12-hour alarm clock: edits time/alarm values and
// drives the LoadTime/LoadAlm strobes, holding each long enough for the 1 s clock.
module time_alarm_setter #(
  parameter int unsigned LOAD_HOLD = 1100,
  parameter int unsigned TIMEOUT   = 10000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ModeBtn,
  input  logic       NextBtn,
  input  logic       IncBtn,
  input  logic [5:0] Cur_Secs,
  input  logic [5:0] Cur_Mins,
  input  logic [3:0] Cur_Hours,
  input  logic       Cur_AM_PM,
  output logic       LoadTime,
  output logic [5:0] SetSecs,
  output logic [5:0] SetMins,
  output logic [3:0] SetHours,
  output logic       Set_AM_PM,
  output logic       LoadAlm,
  output logic [5:0] AlarmMinsIn,
  output logic [3:0] AlarmHoursIn,
  output logic       Alarm_AM_PM_In,
  output logic       AlarmEnable,
  output logic [1:0] EditMode,
  output logic [2:0] EditField
);

  localparam logic [15:0] HoldLast    = 16'(LOAD_HOLD);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StTHour,
    StTMin,
    StTSec,
    StTAmpm,
    StAHour,
    StAMin,
    StAAmpm,
    StTCommit,
    StACommit
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  btn_prev_q;
  logic [3:0]  t_hours_q, t_hours_d;
  logic [5:0]  t_mins_q, t_mins_d;
  logic [5:0]  t_secs_q, t_secs_d;
  logic        t_ampm_q, t_ampm_d;
  logic [3:0]  a_hours_q, a_hours_d;
  logic [5:0]  a_mins_q, a_mins_d;
  logic        a_ampm_q, a_ampm_d;
  logic [3:0]  sh_hours_q, sh_hours_d;
  logic [5:0]  sh_mins_q, sh_mins_d;
  logic        sh_ampm_q, sh_ampm_d;
  logic        alarm_en_q, alarm_en_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        load_time_q, load_time_d;
  logic        load_alm_q, load_alm_d;

  logic [2:0] btn_now;
  logic [2:0] rise;
  logic       mode_p, next_p, inc_p, any_press;
  logic       in_edit;

  function automatic logic [3:0] inc_hour(input logic [3:0] h);
    return (h >= 4'd12 || h == 4'd0) ? 4'd1 : h + 4'd1;
  endfunction

  function automatic logic [5:0] inc_sixty(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // Bit order {Mode, Next, Inc}; one press acts per cycle, Mode highest.
  assign btn_now   = {ModeBtn, NextBtn, IncBtn};
  assign rise      = btn_now & ~btn_prev_q;
  assign mode_p    = rise[2];
  assign next_p    = rise[1] & ~rise[2];
  assign inc_p     = rise[0] & ~rise[1] & ~rise[2];
  assign any_press = |rise;

  assign in_edit = (state_q == StTHour) || (state_q == StTMin) || (state_q == StTSec) ||
                   (state_q == StTAmpm) || (state_q == StAHour) || (state_q == StAMin) ||
                   (state_q == StAAmpm);

  always_comb begin
    state_d     = state_q;
    t_hours_d   = t_hours_q;
    t_mins_d    = t_mins_q;
    t_secs_d    = t_secs_q;
    t_ampm_d    = t_ampm_q;
    a_hours_d   = a_hours_q;
    a_mins_d    = a_mins_q;
    a_ampm_d    = a_ampm_q;
    sh_hours_d  = sh_hours_q;
    sh_mins_d   = sh_mins_q;
    sh_ampm_d   = sh_ampm_q;
    alarm_en_d  = alarm_en_q;
    hold_cnt_d  = 16'd0;
    to_cnt_d    = 16'd0;
    load_time_d = 1'b0;
    load_alm_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mode_p) begin
          state_d   = StTHour;
          t_hours_d = (Cur_Hours == 4'd0 || Cur_Hours > 4'd12) ? 4'd12 : Cur_Hours;
          t_mins_d  = (Cur_Mins > 6'd59) ? 6'd0 : Cur_Mins;
          t_secs_d  = (Cur_Secs > 6'd59) ? 6'd0 : Cur_Secs;
          t_ampm_d  = Cur_AM_PM;
        end else if (inc_p) begin
          alarm_en_d = ~alarm_en_q;
        end
      end
      StTHour, StTMin, StTSec, StTAmpm: begin
        if (mode_p) begin
          state_d   = StAHour;
          a_hours_d = sh_hours_q;
          a_mins_d  = sh_mins_q;
          a_ampm_d  = sh_ampm_q;
        end else if (next_p) begin
          unique case (state_q)
            StTHour: state_d = StTMin;
            StTMin:  state_d = StTSec;
            StTSec:  state_d = StTAmpm;
            default: state_d = StTCommit;
          endcase
        end else if (inc_p) begin
          unique case (state_q)
            StTHour: t_hours_d = inc_hour(t_hours_q);
            StTMin:  t_mins_d  = inc_sixty(t_mins_q);
            StTSec:  t_secs_d  = inc_sixty(t_secs_q);
            default: t_ampm_d  = ~t_ampm_q;
          endcase
        end
      end
      StAHour, StAMin, StAAmpm: begin
        if (mode_p) begin
          state_d   = StIdle;
          a_hours_d = sh_hours_q;
          a_mins_d  = sh_mins_q;
          a_ampm_d  = sh_ampm_q;
        end else if (next_p) begin
          unique case (state_q)
            StAHour: state_d = StAMin;
            StAMin:  state_d = StAAmpm;
            default: begin
              state_d    = StACommit;
              sh_hours_d = a_hours_q;
              sh_mins_d  = a_mins_q;
              sh_ampm_d  = a_ampm_q;
            end
          endcase
        end else if (inc_p) begin
          unique case (state_q)
            StAHour: a_hours_d = inc_hour(a_hours_q);
            StAMin:  a_mins_d  = inc_sixty(a_mins_q);
            default: a_ampm_d  = ~a_ampm_q;
          endcase
        end
      end
      // Strobe rises the cycle after entry and stays up for LOAD_HOLD cycles.
      StTCommit: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d  = hold_cnt_q + 16'd1;
          load_time_d = 1'b1;
        end
      end
      StACommit: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
          load_alm_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Inactivity abort; any press (acted on or not) restarts the count.
    if (in_edit && !any_press) begin
      if (to_cnt_q == TimeoutLast) begin
        state_d   = StIdle;
        a_hours_d = sh_hours_q;
        a_mins_d  = sh_mins_q;
        a_ampm_d  = sh_ampm_q;
      end else begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      btn_prev_q  <= 3'b111;
      t_hours_q   <= 4'd12;
      t_mins_q    <= 6'd0;
      t_secs_q    <= 6'd0;
      t_ampm_q    <= 1'b0;
      a_hours_q   <= 4'd12;
      a_mins_q    <= 6'd0;
      a_ampm_q    <= 1'b0;
      sh_hours_q  <= 4'd12;
      sh_mins_q   <= 6'd0;
      sh_ampm_q   <= 1'b0;
      alarm_en_q  <= 1'b0;
      hold_cnt_q  <= 16'd0;
      to_cnt_q    <= 16'd0;
      load_time_q <= 1'b0;
      load_alm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_prev_q  <= btn_now;
      t_hours_q   <= t_hours_d;
      t_mins_q    <= t_mins_d;
      t_secs_q    <= t_secs_d;
      t_ampm_q    <= t_ampm_d;
      a_hours_q   <= a_hours_d;
      a_mins_q    <= a_mins_d;
      a_ampm_q    <= a_ampm_d;
      sh_hours_q  <= sh_hours_d;
      sh_mins_q   <= sh_mins_d;
      sh_ampm_q   <= sh_ampm_d;
      alarm_en_q  <= alarm_en_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      load_time_q <= load_time_d;
      load_alm_q  <= load_alm_d;
    end
  end

  always_comb begin
    EditMode  = 2'd0;
    EditField = 3'd0;
    unique case (state_q)
      StIdle:    begin EditMode = 2'd0; EditField = 3'd0; end
      StTHour:   begin EditMode = 2'd1; EditField = 3'd1; end
      StTMin:    begin EditMode = 2'd1; EditField = 3'd2; end
      StTSec:    begin EditMode = 2'd1; EditField = 3'd3; end
      StTAmpm:   begin EditMode = 2'd1; EditField = 3'd4; end
      StAHour:   begin EditMode = 2'd2; EditField = 3'd1; end
      StAMin:    begin EditMode = 2'd2; EditField = 3'd2; end
      StAAmpm:   begin EditMode = 2'd2; EditField = 3'd4; end
      StTCommit: begin EditMode = 2'd3; EditField = 3'd0; end
      StACommit: begin EditMode = 2'd3; EditField = 3'd0; end
      default:   begin EditMode = 2'd0; EditField = 3'd0; end
    endcase
  end

  assign LoadTime       = load_time_q;
  assign LoadAlm        = load_alm_q;
  assign SetHours       = t_hours_q;
  assign SetMins        = t_mins_q;
  assign SetSecs        = t_secs_q;
  assign Set_AM_PM      = t_ampm_q;
  assign AlarmHoursIn   = a_hours_q;
  assign AlarmMinsIn    = a_mins_q;
  assign Alarm_AM_PM_In = a_ampm_q;
  assign AlarmEnable    = alarm_en_q;

endmodule

// File: tb/tb_time_alarm_setter.sv
// Directed bench for time_alarm_setter with short hold/timeout values.
module tb_time_alarm_setter;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_btn, next_btn, inc_btn;
  logic [5:0] cur_secs, cur_mins;
  logic [3:0] cur_hours;
  logic       cur_ampm;
  logic       load_time, load_alm, set_ampm, alm_ampm, alarm_en;
  logic [5:0] set_secs, set_mins, alm_mins;
  logic [3:0] set_hours, alm_hours;
  logic [1:0] edit_mode;
  logic [2:0] edit_field;

  int errors = 0;
  int checks = 0;
  int cnt_t, cnt_a;

  always #5 clk = ~clk;

  time_alarm_setter #(
    .LOAD_HOLD(4),
    .TIMEOUT  (20)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .ModeBtn       (mode_btn),
    .NextBtn       (next_btn),
    .IncBtn        (inc_btn),
    .Cur_Secs      (cur_secs),
    .Cur_Mins      (cur_mins),
    .Cur_Hours     (cur_hours),
    .Cur_AM_PM     (cur_ampm),
    .LoadTime      (load_time),
    .SetSecs       (set_secs),
    .SetMins       (set_mins),
    .SetHours      (set_hours),
    .Set_AM_PM     (set_ampm),
    .LoadAlm       (load_alm),
    .AlarmMinsIn   (alm_mins),
    .AlarmHoursIn  (alm_hours),
    .Alarm_AM_PM_In(alm_ampm),
    .AlarmEnable   (alarm_en),
    .EditMode      (edit_mode),
    .EditField     (edit_field)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = Mode, 1 = Next, 2 = Inc
  task automatic press(input int which);
    if (which == 0) mode_btn = 1'b1;
    else if (which == 1) next_btn = 1'b1;
    else inc_btn = 1'b1;
    tick();
    mode_btn = 1'b0;
    next_btn = 1'b0;
    inc_btn  = 1'b0;
    tick();
  endtask

  task automatic count_strobes(input int cycles);
    cnt_t = 0;
    cnt_a = 0;
    for (int i = 0; i < cycles; i++) begin
      if (load_time) cnt_t++;
      if (load_alm) cnt_a++;
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    mode_btn  = 1'b1;
    next_btn  = 1'b1;
    inc_btn   = 1'b1;
    cur_hours = 4'd11;
    cur_mins  = 6'd58;
    cur_secs  = 6'd30;
    cur_ampm  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_load_time", load_time, 0);
    check("rst_set_hours", set_hours, 12);
    check("rst_alm_hours", alm_hours, 12);
    rst = 1'b0;
    tick();
    tick();
    check("held_btn_mode", edit_mode, 0);
    check("held_btn_alarm_en", alarm_en, 0);
    mode_btn = 1'b0;
    next_btn = 1'b0;
    inc_btn  = 1'b0;
    tick();
    press(2);
    check("inc_toggles_en", alarm_en, 1);

    // Time edit from 11:58:30 PM
    press(0);
    check("t_enter_mode", edit_mode, 1);
    check("t_enter_field", edit_field, 1);
    check("t_capture_hours", set_hours, 11);
    check("t_capture_mins", set_mins, 58);
    check("t_capture_secs", set_secs, 30);
    check("t_capture_ampm", set_ampm, 1);
    press(2);
    check("t_hours_12", set_hours, 12);
    press(2);
    check("t_hours_wrap", set_hours, 1);
    press(1);
    check("t_field_min", edit_field, 2);
    press(2);
    check("t_mins_59", set_mins, 59);
    press(2);
    check("t_mins_wrap", set_mins, 0);
    press(1);
    press(1);
    check("t_field_ampm", edit_field, 4);
    press(2);
    check("t_ampm_toggle", set_ampm, 0);
    press(1);
    check("t_commit_mode", edit_mode, 3);
    check("t_commit_strobe", load_time, 1);
    check("t_commit_hours", set_hours, 1);
    check("t_commit_mins", set_mins, 0);
    check("t_commit_secs", set_secs, 30);
    check("t_commit_ampm", set_ampm, 0);
    count_strobes(10);
    check("t_load_len", cnt_t, 4);
    check("t_no_load_alm", cnt_a, 0);
    check("t_back_idle", edit_mode, 0);

    // Alarm edit to 1:05 PM
    press(0);
    press(0);
    check("a_enter_mode", edit_mode, 2);
    check("a_enter_hours", alm_hours, 12);
    press(2);
    press(1);
    for (int i = 0; i < 5; i++) press(2);
    press(1);
    press(2);
    press(1);
    check("a_commit_mode", edit_mode, 3);
    check("a_commit_hours", alm_hours, 1);
    check("a_commit_mins", alm_mins, 5);
    check("a_commit_ampm", alm_ampm, 1);
    count_strobes(10);
    check("a_load_len", cnt_a, 4);
    check("a_no_load_time", cnt_t, 0);
    check("a_back_idle", edit_mode, 0);

    // Abandoned alarm edit times out and restores the shadow
    press(0);
    press(0);
    check("to_shadow_hours", alm_hours, 1);
    for (int i = 0; i < 3; i++) press(2);
    check("to_edit_hours", alm_hours, 4);
    count_strobes(10);
    check("to_still_editing", edit_mode, 2);
    count_strobes(15);
    check("to_no_load_alm", cnt_a, 0);
    check("to_idle", edit_mode, 0);
    check("to_restore_hours", alm_hours, 1);
    check("to_restore_mins", alm_mins, 5);

    // Mode wins over a simultaneous Inc
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    tick();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    tick();
    check("prio_mode", edit_mode, 1);
    check("prio_en_kept", alarm_en, 1);

    // Reset during the second LoadTime cycle
    for (int i = 0; i < 4; i++) press(1);
    check("r_strobe_1", load_time, 1);
    tick();
    check("r_strobe_2", load_time, 1);
    rst = 1'b1;
    tick();
    check("r_load_time", load_time, 0);
    check("r_set_hours", set_hours, 12);
    check("r_mode", edit_mode, 0);
    check("r_alarm_en", alarm_en, 0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk) begin
    if (load_time && load_alm) begin
      errors++;
      $display("FAIL both_strobes: got LoadTime=1 LoadAlm=1 expected at most one high");
    end
  end

endmodule
